// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: M-field bit positions, access-size codes,
// memory-unit state encoding and address-alignment helpers.
package mips_pkg;

  localparam int unsigned M_MEMREAD       = 0;
  localparam int unsigned M_MEMWRITE      = 1;
  localparam int unsigned M_SIZE_LSB      = 2;
  localparam int unsigned M_SIZE_MSB      = 3;
  localparam int unsigned IR_UNSIGNED_BIT = 28;

  // 2'b11 is unused by the decoder and behaves as a word access.
  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mau_state_e;

  function automatic logic [1:0] align_lo(input mem_size_e size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return lo;
      SZ_HALF: return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(input mem_size_e size, input logic [1:0] lo);
    return align_lo(size, lo) != lo;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
interface mem_access_unit_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store-data replication, byte enables and load
// extraction with sign/zero extension.
module mem_lane_align
  import mips_pkg::*;
(
  input  mem_size_e   size,
  input  logic [1:0]  lane_lo,
  input  logic        zero_ext,
  input  logic [31:0] store_data,
  input  logic [31:0] load_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [15:0] half_v;
  logic [7:0]  byte_v;

  always_comb begin
    be     = 4'b1111;
    wdata  = store_data;
    rdata  = load_data;
    half_v = '0;
    byte_v = '0;
    case (size)
      SZ_HALF: begin
        be     = lane_lo[1] ? 4'b1100 : 4'b0011;
        wdata  = {2{store_data[15:0]}};
        half_v = lane_lo[1] ? load_data[31:16] : load_data[15:0];
        rdata  = zero_ext ? {16'h0000, half_v} : {{16{half_v[15]}}, half_v};
      end
      SZ_BYTE: begin
        be     = 4'b0001 << lane_lo;
        wdata  = {4{store_data[7:0]}};
        byte_v = load_data[{lane_lo, 3'b000} +: 8];
        rdata  = zero_ext ? {24'h000000, byte_v} : {{24{byte_v[7]}}, byte_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: issues data-memory accesses with ack timeout and registers MEM/WB.
// Optional MEM_ALIGN_TRAP_EN: misaligned accesses raise BUS_ERR instead of being aligned.
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] PC_in,
  input  logic [31:0] IR_in,
  input  logic [31:0] B_in,
  input  logic [31:0] ALUout_in,
  input  logic [31:0] Jal_data_in,
  input  logic [4:0]  WR_in,
  input  logic [3:0]  M_in,
  input  logic [1:0]  WB_in,
  input  logic        HALT_in,
  mem_access_unit_if.master dm,
  output logic [31:0] PC_out,
  output logic [31:0] IR_out,
  output logic [31:0] ALUout_out,
  output logic [31:0] MemData_out,
  output logic [31:0] Jal_data_out,
  output logic [4:0]  WR_out,
  output logic [1:0]  WB_out,
  output logic        HALT_out,
  output logic        STALL,
  output logic        BUS_ERR
);

  mau_state_e  state, state_nx;
  logic [7:0]  busy_cnt;
  mem_size_e   size;
  logic [1:0]  lane_lo;
  logic        mem_op, is_load, trap;
  logic        stall_c, capture, wb_kill, err_set, issue, ack_done;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, ld_data;

  assign mem_op  = M_in[M_MEMREAD] | M_in[M_MEMWRITE];
  assign is_load = M_in[M_MEMREAD] & ~M_in[M_MEMWRITE];
  assign size    = mem_size_e'(M_in[M_SIZE_MSB:M_SIZE_LSB]);
  assign lane_lo = align_lo(size, ALUout_in[1:0]);

`ifdef MEM_ALIGN_TRAP_EN
  assign trap = mem_op & misaligned(size, ALUout_in[1:0]);
`else
  assign trap = 1'b0;
`endif

  mem_lane_align u_lane (
    .size       (size),
    .lane_lo    (lane_lo),
    .zero_ext   (IR_in[IR_UNSIGNED_BIT]),
    .store_data (B_in),
    .load_data  (dm.dm_rdata),
    .be         (be_c),
    .wdata      (wdata_c),
    .rdata      (ld_data)
  );

  always_comb begin
    state_nx = state;
    stall_c  = 1'b0;
    capture  = 1'b0;
    wb_kill  = 1'b0;
    err_set  = 1'b0;
    issue    = 1'b0;
    ack_done = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (mem_op && !trap) begin
          stall_c  = 1'b1;
          issue    = 1'b1;
          state_nx = ST_BUSY;
        end else begin
          capture = 1'b1;
          wb_kill = trap;
          err_set = trap;
        end
      end
      ST_BUSY: begin
        // An ack in the timeout cycle still counts as a normal completion.
        if (dm.dm_ack) begin
          capture  = 1'b1;
          ack_done = 1'b1;
          state_nx = ST_IDLE;
        end else if (busy_cnt == 8'(ACK_TIMEOUT - 1)) begin
          capture  = 1'b1;
          wb_kill  = 1'b1;
          err_set  = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
    endcase
  end

  assign STALL     = stall_c & ~RST;
  assign dm.dm_req = (state == ST_BUSY);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= ST_IDLE;
      busy_cnt     <= '0;
      dm.dm_we     <= 1'b0;
      dm.dm_addr   <= '0;
      dm.dm_wdata  <= '0;
      dm.dm_be     <= '0;
      PC_out       <= '0;
      IR_out       <= '0;
      ALUout_out   <= '0;
      MemData_out  <= '0;
      Jal_data_out <= '0;
      WR_out       <= '0;
      WB_out       <= '0;
      HALT_out     <= 1'b0;
      BUS_ERR      <= 1'b0;
    end else begin
      state <= state_nx;
      if (issue) begin
        busy_cnt    <= '0;
        dm.dm_we    <= M_in[M_MEMWRITE];
        dm.dm_addr  <= {ALUout_in[31:2], 2'b00};
        dm.dm_wdata <= wdata_c;
        dm.dm_be    <= be_c;
      end else if (state == ST_BUSY) begin
        busy_cnt <= busy_cnt + 8'd1;
      end
      if (capture) begin
        PC_out       <= PC_in;
        IR_out       <= IR_in;
        ALUout_out   <= ALUout_in;
        MemData_out  <= (ack_done && is_load) ? ld_data : '0;
        Jal_data_out <= Jal_data_in;
        WR_out       <= WR_in;
        WB_out       <= wb_kill ? 2'b00 : WB_in;
        HALT_out     <= HALT_in;
      end
      if (err_set) BUS_ERR <= 1'b1;
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 16, the number of BUSY cycles without dm_ack before a bus error is declared (range 2..255).
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports PC_in, IR_in, B_in, ALUout_in, Jal_data_in, input, 32 each, the EX/MEM latch contents; B_in is store data and ALUout_in is the address.
REQ-005 SHALL have ports WR_in input 5, M_in input 4, WB_in input 2, and HALT_in input 1; M_in[0] is MemRead, M_in[1] is MemWrite, and M_in[3:2] is size (00 word, 01 half, 10 byte).
REQ-006 SHALL have ports dm_req, dm_we (output, 1), dm_addr, dm_wdata (output, 32), dm_be (output, 4), dm_ack (input, 1) and dm_rdata (input, 32), forming the data-memory handshake.
REQ-007 SHALL have ports PC_out, IR_out, ALUout_out, MemData_out, Jal_data_out (output, 32), WR_out (output, 5), WB_out (output, 2) and HALT_out (output, 1), the registered MEM/WB outputs.
REQ-008 SHALL have port STALL, output, 1; while it is high, upstream holds the EX/MEM contents.
REQ-009 SHALL have port BUS_ERR, output, 1, which is sticky until reset.

Function
REQ-010 SHALL implement states IDLE and BUSY.
REQ-011 SHALL treat an instruction as a memory op when M_in[0] or M_in[1] is set; MemWrite wins if both are set.
REQ-012 SHALL, in IDLE with no memory op, hold STALL=0 and register all *_in to the *_out ports at the next edge (1-cycle latency), with MemData_out=0.
REQ-013 SHALL, in IDLE with a memory op, assert STALL, go to BUSY, and register dm_addr={ALUout_in[31:2],2'b00}, dm_we, dm_be and dm_wdata.
REQ-014 SHALL, in BUSY, hold dm_req=1 with all dm_* stable until dm_ack, and keep STALL=1 while dm_ack=0.
REQ-015 SHALL, in the cycle dm_ack=1 in BUSY, drive STALL=0 combinationally, and at that edge register the MEM/WB outputs, deassert dm_req and return to IDLE; minimum memory-op latency is 2 cycles.
REQ-016 SHALL ignore dm_ack in IDLE.
REQ-017 SHALL hold the MEM/WB outputs while STALL=1.
REQ-018 SHALL set byte enables by size: word=4'b1111; half=ALUout_in[1]?4'b1100:4'b0011; byte=4'b0001<<ALUout_in[1:0].
REQ-019 SHALL replicate store data across lanes: byte to all 4 lanes, half to both halves.
REQ-020 SHALL, for a load, select MemData_out from dm_rdata using the same lane, zero-extending when IR_in[28]=1 (lbu/lhu) and sign-extending otherwise.
REQ-021 SHALL keep a BUSY cycle counter; when it reaches ACK_TIMEOUT with no ack, it SHALL set BUS_ERR, drop dm_req, set MemData_out=0, register outputs with WB_out=0, and return to IDLE with STALL=0.
REQ-022 SHALL treat dm_ack arriving in the same cycle as the timeout as a normal completion, with no error.
REQ-023 SHALL pass HALT_in through to HALT_out like other fields, delayed behind any pending memory op.

Reset
REQ-024 SHALL, on RST, asynchronously force state IDLE, counter 0, every output to 0 (STALL=0, dm_req=0, BUS_ERR=0), and abandon any in-flight request without waiting for dm_ack.

Configuration
REQ-025 SHALL, with MEM_ALIGN_TRAP_EN defined, treat a misaligned access (half with ALUout_in[0]=1, word with ALUout_in[1:0]!=0) as follows: no dm_req, BUS_ERR set, outputs registered at the next edge with WB_out=0, STALL=0.
REQ-026 SHALL, without MEM_ALIGN_TRAP_EN, force misaligned low address bits to the size alignment and perform the access normally.

Structure
REQ-027 SHALL take the M_in bit positions, size encodings and state encoding from the shared package mips_pkg.
REQ-028 SHALL place lane selection and extension in a combinational sub-module mem_lane_align, used for both store replication and load extraction.

Verification
REQ-029 SHALL cover ALU-only: M_in=0, ALUout_in=0x1234 -> ALUout_out=0x1234 one cycle later, STALL never high.
REQ-030 SHALL cover load byte signed: ALUout_in=0x103, dm_rdata=0x80xxxxxx, ack after 3 cycles -> dm_be=4'b1000, MemData_out=0xFFFFFF80, STALL high 3 cycles.
REQ-031 SHALL cover store half: ALUout_in=0x202, B_in=0x0000ABCD -> dm_wdata=0xABCDABCD, dm_be=4'b1100, dm_we=1.
REQ-032 SHALL cover timeout: no ack, ACK_TIMEOUT=16 -> BUS_ERR=1 after 16 BUSY cycles, WB_out=0, STALL released.
REQ-033 SHALL cover reset mid-BUSY: RST pulse -> dm_req=0 and all outputs 0 immediately; a following load completes normally.
REQ-034 SHALL cover misaligned word at 0x101 -> with MEM_ALIGN_TRAP_EN, BUS_ERR=1 and no dm_req; without it, dm_addr=0x100 and dm_be=4'b1111.
